lsu_mem_port: RTL and testbench
===============================

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
Parameters: none.
REQ-001 SHALL have ports: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: req_valid  input  1  core issues a load/store request.
REQ-004 SHALL have: req_ready  output  1  block can accept a request.
REQ-005 SHALL have: req_we  input  1  1 = store, 0 = load.
REQ-006 SHALL have: req_funct3  input  3  RV32I size/sign code: LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2.
REQ-007 SHALL have: req_addr  input  32  byte address.
REQ-008 SHALL have: req_wdata  input  32  store data, right-justified.
REQ-009 SHALL have: resp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have: resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-011 SHALL have: resp_err  output  1  misaligned or illegal request; valid with resp_valid.
REQ-012 SHALL have: MemRead  output  1  word read strobe to data memory.
REQ-013 SHALL have: MemWrite  output  1  word write strobe; memory writes on the next rising clk.
REQ-014 SHALL have: addr  output  32  word address to memory, {req_addr[31:2],2'b00}.
REQ-015 SHALL have: wdata  output  32  full word to write.
REQ-016 SHALL have: rdata  input  32  combinational read data, valid in the same cycle MemRead=1.

Function
REQ-017 SHALL implement FSM states IDLE, RD, RMW_RD, WR, RESP; req_ready=1 only in IDLE.
REQ-018 SHALL register req_we, req_funct3, req_addr, req_wdata on handshake (req_valid & req_ready); inputs ignored otherwise.
REQ-019 SHALL classify at accept: error if funct3 is 3, 6 or 7 (load) or >2 (store), or if halfword addr[0]!=0, or if word addr[1:0]!=0.
REQ-020 SHALL route from IDLE on handshake: error -> RESP; load -> RD; SW -> WR; SB/SH -> RMW_RD.
REQ-021 SHALL in RD assert MemRead=1 and capture the extracted load value; next state RESP.
REQ-022 SHALL extract little-endian: byte k = word[8k+7:8k], halfword at addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-023 SHALL in RMW_RD assert MemRead=1 and latch rdata with the addressed byte/halfword replaced by req_wdata[7:0]/[15:0]; next state WR.
REQ-024 SHALL in WR assert MemWrite=1 with wdata = merged word (SB/SH) or req_wdata (SW); next state RESP.
REQ-025 SHALL in RESP assert resp_valid=1 for exactly one cycle; next state IDLE. There is no response backpressure.
REQ-026 Latency from accept to resp_valid SHALL be: error 1 cycle, load 2, SW 2, SB/SH 3.
REQ-027 SHALL keep MemRead and MemWrite never both 1, and 0 outside RD/RMW_RD and WR respectively.
REQ-028 SHALL hold addr stable from the cycle after accept through RESP; erroring requests SHALL cause no memory strobe.
REQ-029 SHALL hold resp_rdata and resp_err until the next RESP; they are meaningful only while resp_valid=1.
REQ-030 SHALL accept back-to-back requests: a new handshake may occur in the cycle after RESP.

Reset
REQ-031 SHALL on rst=1, immediately and regardless of clk, force state=IDLE and set req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, MemRead=0, MemWrite=0, addr=0, wdata=0.
REQ-032 SHALL abandon any in-flight request on reset mid-operation: no later MemWrite and no response for it.

Verification
REQ-033 Memory word0=0xDEADBEEF, word1=0xCAFEBABE; LB @0x3 -> resp_rdata=0xFFFFFFDE 2 cycles after accept; LBU @0x4 -> 0x000000BE.
REQ-034 LH @0x2 -> 0xFFFFDEAD; LHU @0x6 -> 0x0000CAFE; LW @0x4 -> 0xCAFEBABE, resp_err=0.
REQ-035 SB @0x1 wdata=0x12345655 -> MemRead cycle, then MemWrite with wdata=0xDEAD55EF, resp 3 cycles after accept; then LW @0x0 -> 0xDEAD55EF.
REQ-036 LW @0x6, SH @0x3 and load funct3=3 -> resp_err=1, resp_rdata=0, response 1 cycle after accept, MemRead and MemWrite stay 0.
REQ-037 SH @0x4 wdata=0x0000BEEF, rst pulsed during the RMW_RD cycle -> MemWrite never asserts, no resp_valid, req_ready=1, word1 remains 0xCAFEBABE.
REQ-038 Back-to-back SW @0x8 data 0x11223344 then LW @0x8 held on req_valid -> second accept in the cycle after first RESP; LW returns 0x11223344.

Source files
------------

// File: rtl/lsu_mem_port.sv
// RV32I load/store port onto a word-wide memory; sub-word stores use a read-modify-write.
// Accept-to-response latency: error 1, load 2, SW 2, SB/SH 3; req_ready only in IDLE, no response backpressure.
module lsu_mem_port (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

  state_t      state;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [15:0] r_wd;
  logic        hs;
  logic        bad;

  assign hs = req_valid & req_ready;

  always_comb begin
    bad = 1'b0;
    if (req_we) bad = (req_funct3 > 3'd2);
    else        bad = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11);
    if (req_funct3[1:0] == 2'b01 && req_addr[0])          bad = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) bad = 1'b1;
  end

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    extract = {{24{b[7]}}, b};
      3'd1:    extract = {{16{h[15]}}, h};
      3'd4:    extract = {24'd0, b};
      3'd5:    extract = {16'd0, h};
      default: extract = w;
    endcase
  endfunction

  // Replace only the addressed lane; the rest of the word comes from memory.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic half,
                                        input logic [1:0] off, input logic [15:0] d);
    merge = w;
    if (half) merge[{off[1], 4'b0000} +: 16] = d;
    else      merge[{off, 3'b000} +: 8]      = d[7:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      addr       <= 32'd0;
      wdata      <= 32'd0;
      r_f3       <= 3'd0;
      r_off      <= 2'd0;
      r_wd       <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            r_f3      <= req_funct3;
            r_off     <= req_addr[1:0];
            r_wd      <= req_wdata[15:0];
            addr      <= {req_addr[31:2], 2'b00};
            req_ready <= 1'b0;
            if (bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else if (!req_we) begin
              state   <= RD;
              MemRead <= 1'b1;
            end else if (req_funct3[1:0] == 2'b10) begin
              state    <= WR;
              MemWrite <= 1'b1;
              wdata    <= req_wdata;
            end else begin
              state   <= RMW_RD;
              MemRead <= 1'b1;
            end
          end
        end
        RD: begin
          MemRead    <= 1'b0;
          resp_rdata <= extract(rdata, r_f3, r_off);
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RMW_RD: begin
          MemRead  <= 1'b0;
          MemWrite <= 1'b1;
          wdata    <= merge(rdata, r_f3[0], r_off, r_wd);
          state    <= WR;
        end
        WR: begin
          MemWrite   <= 1'b0;
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          MemRead    <= 1'b0;
          MemWrite   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed + random bench for lsu_mem_port against a byte-level memory model.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        MemRead, MemWrite;
  logic [31:0] addr, wdata, rdata;

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  logic        mem_init;
  int          vectors = 0;
  int          miscompares = 0;

  lsu_mem_port dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  assign rdata = mem[addr[5:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= ref_mem[i];
    end else if (MemWrite) begin
      mem[addr[5:2]] <= wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outcome of one request, from byte sizes, masks and shifts.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic err, output logic [31:0] rd,
                       output logic [31:0] nw, output int lat, output int nrd, output int nwr);
    int nbytes, sh;
    logic [31:0] old, mask, v;
    nbytes = 1 << f3[1:0];
    err = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    if (nbytes <= 4 && (int'(a[5:0]) % nbytes) != 0) err = 1'b1;
    old  = ref_mem[a[5:2]];
    sh   = 8 * (int'(a[5:0]) % 4);
    mask = (nbytes >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    rd = 32'd0; nw = old;
    if (err) begin
      lat = 1; nrd = 0; nwr = 0;
    end else if (!we) begin
      v = (old >> sh) & mask;
      if (!f3[2] && nbytes < 4 && v > (mask >> 1)) v = v - mask - 32'd1;
      rd = v; lat = 2; nrd = 1; nwr = 0;
    end else begin
      nw  = (old & ~(mask << sh)) | ((wd & mask) << sh);
      lat = (nbytes == 4) ? 2 : 3;
      nrd = (nbytes == 4) ? 0 : 1;
      nwr = 1;
    end
  endtask

  // Called and returns at a falling edge; returns at the falling edge of the response cycle.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] got, output int waited);
    logic        e_err;
    logic [31:0] e_rd, e_nw;
    int          e_lat, e_nrd, e_nwr, lat, nrd, nwr;
    model(we, f3, a, wd, e_err, e_rd, e_nw, e_lat, e_nrd, e_nwr);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    got = 32'd0;
    if (!req_ready) begin
      chk("ACCEPT_TIMEOUT", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = $urandom_range(1); req_funct3 = $urandom_range(7);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0; nrd = 0; nwr = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (MemRead && MemWrite) chk("BOTH_STROBES", 32'd1, 32'd0);
      if (MemRead) begin
        nrd++;
        chk("RD_ADDR", addr, a & ~32'd3);
      end
      if (MemWrite) begin
        nwr++;
        chk("WR_ADDR", addr, a & ~32'd3);
        chk("WR_DATA", wdata, e_nw);
      end
      if (resp_valid) break;
    end
    chk("RESP_SEEN", resp_valid, 1'b1);
    chk("LATENCY", lat, e_lat);
    chk("RESP_ERR", resp_err, e_err);
    chk("RESP_RDATA", resp_rdata, e_rd);
    chk("N_MEMREAD", nrd, e_nrd);
    chk("N_MEMWRITE", nwr, e_nwr);
    if (we && !e_err) ref_mem[a[5:2]] = e_nw;
    got = resp_rdata;
  endtask

  initial begin
    logic [31:0] got, hold;
    int          w, exp_w;
    logic        seen;

    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
    ref_mem[0] = 32'hDEADBEEF;
    ref_mem[1] = 32'hCAFEBABE;
    #1;
    chk("RST_READY", req_ready, 1'b1);
    chk("RST_RVALID", resp_valid, 1'b0);
    chk("RST_RERR", resp_err, 1'b0);
    chk("RST_RDATA", resp_rdata, 32'd0);
    chk("RST_MEMREAD", MemRead, 1'b0);
    chk("RST_MEMWRITE", MemWrite, 1'b0);
    chk("RST_ADDR", addr, 32'd0);
    chk("RST_WDATA", wdata, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0; mem_init = 1'b0;

    do_req(1'b0, 3'd0, 32'h3, 32'd0, got, w); chk("LB_3", got, 32'hFFFFFFDE);
    do_req(1'b0, 3'd4, 32'h4, 32'd0, got, w); chk("LBU_4", got, 32'h000000BE);
    do_req(1'b0, 3'd1, 32'h2, 32'd0, got, w); chk("LH_2", got, 32'hFFFFDEAD);
    do_req(1'b0, 3'd5, 32'h6, 32'd0, got, w); chk("LHU_6", got, 32'h0000CAFE);
    do_req(1'b0, 3'd2, 32'h4, 32'd0, got, w); chk("LW_4", got, 32'hCAFEBABE);
    do_req(1'b1, 3'd0, 32'h1, 32'h12345655, got, w);
    do_req(1'b0, 3'd2, 32'h0, 32'd0, got, w); chk("LW_0_AFTER_SB", got, 32'hDEAD55EF);
    do_req(1'b0, 3'd2, 32'h6, 32'd0, got, w); chk("ERR_LW6_DATA", got, 32'd0);
    do_req(1'b1, 3'd1, 32'h3, 32'h5A5A5A5A, got, w); chk("ERR_SH3_DATA", got, 32'd0);
    do_req(1'b0, 3'd3, 32'h0, 32'd0, got, w); chk("ERR_F3_3_DATA", got, 32'd0);

    // Second request already waiting while the first responds.
    do_req(1'b1, 3'd2, 32'h8, 32'h11223344, got, w);
    do_req(1'b0, 3'd2, 32'h8, 32'd0, got, w);
    chk("B2B_WAIT", w, 1);
    chk("B2B_LW", got, 32'h11223344);

    // Reset in the RMW read cycle of a halfword store.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h4; req_wdata = 32'h0000BEEF;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("RMW_MEMREAD", MemRead, 1'b1);
    rst = 1'b1;
    #1;
    chk("MIDRST_READY", req_ready, 1'b1);
    chk("MIDRST_MEMREAD", MemRead, 1'b0);
    chk("MIDRST_MEMWRITE", MemWrite, 1'b0);
    chk("MIDRST_RVALID", resp_valid, 1'b0);
    chk("MIDRST_ADDR", addr, 32'd0);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (MemWrite || resp_valid) seen = 1'b1;
    end
    chk("ABANDONED", seen, 1'b0);
    chk("IDLE_READY", req_ready, 1'b1);
    do_req(1'b0, 3'd2, 32'h4, 32'd0, got, w); chk("WORD1_KEPT", got, 32'hCAFEBABE);

    exp_w = 1;
    for (int n = 0; n < 40; n++) begin
      do_req(1'($urandom_range(1)), 3'($urandom_range(7)), 32'($urandom_range(63)),
             $urandom, got, w);
      chk("RAND_WAIT", w, exp_w);
      if ($urandom_range(1) == 1) begin
        hold = got;
        @(negedge clk);
        chk("RESP_ONE_CYCLE", resp_valid, 1'b0);
        chk("RDATA_HELD", resp_rdata, hold);
        chk("READY_IDLE", req_ready, 1'b1);
        exp_w = 0;
      end else begin
        exp_w = 1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
